// File: rtl/ifetch_queue.sv
// Instruction fetch stage: owns the PC, requests words from instruction
// memory and buffers in-order responses in a small FIFO for decode.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   redirect_valid/_pc        one-cycle restart of fetch at a new PC
//   imem_req/addr/gnt         fetch request channel (addr = current PC)
//   imem_rvalid/rdata         in-order response channel
//   id_valid/ready/inst/pc    FIFO head towards decode
module ifetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] infl_q, infl_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [PW-1:0] rp_q, rp_d, wp_q, wp_d;
    logic [PW-1:0] tr_q, tr_d, tw_q, tw_d;

    logic [31:0] inst_mem_q [DEPTH];
    logic [31:0] pc_mem_q   [DEPTH];
    logic [31:0] tag_q      [DEPTH];

    logic        grant;
    logic        push;
    logic        pop;
    logic [CW:0] used;

    // Buffered plus in-flight words share one credit pool of DEPTH.
    assign used      = {1'b0, cnt_q} + {1'b0, infl_q};
    assign imem_req  = !rst && !redirect_valid
                       && (used < (CW+1)'(DEPTH));
    assign imem_addr = pc_q;
    assign grant     = imem_req && imem_gnt;

    // A response landing in a redirect cycle is old-path: never pushed.
    assign push = !rst && imem_rvalid && !redirect_valid
                  && (drop_q == '0);

    assign id_valid = (cnt_q != '0);
    assign pop      = id_valid && id_ready;
    assign id_inst  = id_valid ? inst_mem_q[rp_q] : NOP;
    assign id_pc    = id_valid ? pc_mem_q[rp_q] : 32'h0;

    always_comb begin
        pc_d   = pc_q;
        cnt_d  = cnt_q;
        infl_d = infl_q + CW'(grant) - CW'(imem_rvalid);
        drop_d = drop_q;
        rp_d   = rp_q;
        wp_d   = wp_q;
        tr_d   = tr_q;
        tw_d   = tw_q;
        if (grant) begin
            pc_d = pc_q + 32'd4;
            tw_d = tw_q + PW'(1);
        end
        if (imem_rvalid) begin
            tr_d = tr_q + PW'(1);
        end
        if (redirect_valid) begin
            pc_d   = redirect_pc;
            cnt_d  = '0;
            rp_d   = wp_q;
            // Everything still outstanding belongs to the old path.
            drop_d = infl_q - CW'(imem_rvalid);
        end else begin
            if (imem_rvalid && (drop_q != '0)) begin
                drop_d = drop_q - CW'(1);
            end
            if (push) begin
                wp_d = wp_q + PW'(1);
            end
            if (pop) begin
                rp_d = rp_q + PW'(1);
            end
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q   <= RESET_PC;
            cnt_q  <= '0;
            infl_q <= '0;
            drop_q <= '0;
            rp_q   <= '0;
            wp_q   <= '0;
            tr_q   <= '0;
            tw_q   <= '0;
        end else begin
            pc_q   <= pc_d;
            cnt_q  <= cnt_d;
            infl_q <= infl_d;
            drop_q <= drop_d;
            rp_q   <= rp_d;
            wp_q   <= wp_d;
            tr_q   <= tr_d;
            tw_q   <= tw_d;
        end
    end

    // Storage needs no reset: pointers and counts qualify every read.
    always_ff @(posedge clk) begin
        if (grant) begin
            tag_q[tw_q] <= pc_q;
        end
        if (push) begin
            inst_mem_q[wp_q] <= imem_rdata;
            pc_mem_q[wp_q]   <= tag_q[tr_q];
        end
    end

    assert property (@(posedge clk) disable iff (rst)
        imem_rvalid |-> (infl_q != '0));

endmodule
